// File: rtl/rom_stream_reader_pkg.sv
// Shared types and defaults for the ROM burst reader.
package rom_stream_reader_pkg;

    localparam int unsigned ROM_ADDR_WIDTH_DEF = 8;
    localparam int unsigned ROM_DATA_WIDTH_DEF = 8;
    localparam int unsigned BUF_DEPTH          = 2;
    localparam int unsigned CNT_WIDTH          = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream from the reader to the serializer.
interface rom_stream_reader_if #(
    parameter int unsigned DW = 8
) ();
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          in_ready;

    modport master (output out_data, output out_valid, input in_ready);
    modport slave  (input out_data, input out_valid, output in_ready);
endinterface

// File: rtl/rom_stream_reader_fifo2_skid.sv
// Two-entry buffer; head register feeds the stream directly.
module fifo2_skid #(
    parameter int unsigned DW = 8
) (
    input  logic          in_clk,
    input  logic          in_rst_n,
    input  logic          in_push,
    input  logic [DW-1:0] in_data,
    input  logic          in_pop,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic [1:0]    out_count
);

    logic [DW-1:0] tail_q;
    logic [1:0]    count_d;

    always_comb begin
        count_d = out_count;
        if (in_push && !in_pop)      count_d = out_count + 2'd1;
        else if (!in_push && in_pop) count_d = out_count - 2'd1;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_data  <= '0;
            tail_q    <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            out_count <= count_d;
            out_valid <= (count_d != 2'd0);
            if (in_push && in_pop) begin
                if (out_count == 2'd2) begin
                    out_data <= tail_q;
                    tail_q   <= in_data;
                end else begin
                    out_data <= in_data;
                end
            end else if (in_pop) begin
                if (out_count == 2'd2) out_data <= tail_q;
            end else if (in_push) begin
                if (out_count == 2'd0) out_data <= in_data;
                else                   tail_q   <= in_data;
            end
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Burst read engine: issues ROM addresses base..base+len-1 and streams the words
// out through a 2-entry buffer that hides the ROM's registered read latency.
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int unsigned ROM_ADDR_WIDTH = ROM_ADDR_WIDTH_DEF,
    parameter int unsigned ROM_DATA_WIDTH = ROM_DATA_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH      = ROM_ADDR_WIDTH + 1
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic                      in_start,
    input  logic [ROM_ADDR_WIDTH-1:0] in_base_addr,
    input  logic [LEN_WIDTH-1:0]      in_len,
    output logic [ROM_ADDR_WIDTH-1:0] out_rom_addr,
    input  logic [ROM_DATA_WIDTH-1:0] in_rom_data,
    rom_stream_reader_if.master       strm,
    output logic                      out_busy,
    output logic                      out_done
);

    state_e                    state_q, state_d;
    logic [ROM_ADDR_WIDTH-1:0] addr_d;
    logic [LEN_WIDTH-1:0]      remain_q, remain_d;
    logic                      arm_q, arm_d;
    logic                      rd_inflight_q;
    logic                      busy_d, done_d;

    logic [ROM_DATA_WIDTH-1:0] buf_data;
    logic                      buf_valid;
    logic [CNT_WIDTH-1:0]      buf_count;
    logic                      pop, push, room, issue;

    assign pop  = buf_valid & strm.in_ready;
    assign push = rd_inflight_q;
    // Buffered words plus the read in flight, net of this cycle's pop, must stay below depth.
    assign room = ((3'(buf_count) + 3'(rd_inflight_q)) < (3'(BUF_DEPTH) + 3'(pop)));
    // arm_q holds off the first issue one cycle after the address is loaded.
    assign issue = (state_q == ST_FETCH) & arm_q & room;

    assign strm.out_data  = buf_data;
    assign strm.out_valid = buf_valid;

    fifo2_skid #(.DW(ROM_DATA_WIDTH)) u_fifo (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_push   (push),
        .in_data   (in_rom_data),
        .in_pop    (pop),
        .out_data  (buf_data),
        .out_valid (buf_valid),
        .out_count (buf_count)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = out_rom_addr;
        remain_d = remain_q;
        arm_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    if (in_len != '0) begin
                        state_d  = ST_FETCH;
                        addr_d   = in_base_addr;
                        remain_d = in_len;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                arm_d = 1'b1;
                if (issue) begin
                    remain_d = remain_q - LEN_WIDTH'(1);
                    // The last address stays on the bus so it holds when idle.
                    if (remain_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
                    else                          addr_d  = out_rom_addr + ROM_ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (pop && (buf_count == 2'd1) && !rd_inflight_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q       <= ST_IDLE;
            out_rom_addr  <= '0;
            remain_q      <= '0;
            arm_q         <= 1'b0;
            rd_inflight_q <= 1'b0;
            out_busy      <= 1'b0;
            out_done      <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_rom_addr  <= addr_d;
            remain_q      <= remain_d;
            arm_q         <= arm_d;
            rd_inflight_q <= issue;
            out_busy      <= busy_d;
            out_done      <= done_d;
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a registered ROM[i]=i model.
module tb_rom_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] len;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       busy;
    logic       done;
    logic [7:0] rom [256];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [7:0] got_q [$];
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;

    rom_stream_reader_if #(.DW(8)) strm ();

    rom_stream_reader dut (
        .in_clk       (clk),
        .in_rst_n     (rst_n),
        .in_start     (start),
        .in_base_addr (base_addr),
        .in_len       (len),
        .out_rom_addr (rom_addr),
        .in_rom_data  (rom_data),
        .strm         (strm),
        .out_busy     (busy),
        .out_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream monitor: collects accepted words, checks stall stability and buffer overflow.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                check("stall_valid", 32'(strm.out_valid), 32'd1);
                check("stall_data", 32'(strm.out_data), 32'(prev_data));
            end
            if (dut.push)
                check("no_overflow", 32'(dut.u_fifo.out_count == 2'd2 && !dut.pop), 32'd0);
            if (strm.out_valid && strm.in_ready) got_q.push_back(strm.out_data);
            if (done) done_cnt++;
            stall_prev = strm.out_valid && !strm.in_ready;
            prev_data  = strm.out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        logic [7:0] exp_last_addr;
    } vec_t;

    task automatic pulse_start(input logic [7:0] b, input logic [8:0] l);
        @(posedge clk); #1;
        base_addr = b; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        pulse_start(v.base, v.len);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("busy_first", 32'(busy), 32'd1);
        end while (!strm.out_valid && lat < 20);
        check("first_latency", 32'(lat), 32'd4);
        for (int i = 0; i < int'(v.len); i++) begin
            if (i > 0) @(negedge clk);
            check("word_valid", 32'(strm.out_valid), 32'd1);
            check("word_data", 32'(strm.out_data), 32'(8'(v.base + 8'(i))));
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("valid_after", 32'(strm.out_valid), 32'd0);
        check("addr_hold", 32'(rom_addr), 32'(v.exp_last_addr));
        @(negedge clk);
        check("done_cleared", 32'(done), 32'd0);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(done_cnt != 0), 32'd1);
    endtask

    vec_t vecs [6];
    logic [7:0] exp_w;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i);
        vecs[0] = '{8'h10, 9'd4,   8'h13};
        vecs[1] = '{8'hFE, 9'd4,   8'h01};
        vecs[2] = '{8'h00, 9'd1,   8'h00};
        vecs[3] = '{8'h80, 9'd3,   8'h82};
        vecs[4] = '{8'hFF, 9'd2,   8'h00};
        vecs[5] = '{8'h00, 9'd256, 8'hFF};

        rst_n = 1'b0; start = 1'b0; base_addr = 8'h00; len = 9'd0;
        strm.in_ready = 1'b1;
        #12;
        check("rst_valid", 32'(strm.out_valid), 32'd0);
        check("rst_data", 32'(strm.out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Straight bursts with ready held high.
        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // Zero-length burst: done only, no busy, no stream words.
        got_q.delete(); done_cnt = 0;
        pulse_start(8'h40, 9'd0);
        @(negedge clk);
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_valid", 32'(strm.out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("len0_quiet", 32'({busy, strm.out_valid}), 32'd0);
        end
        check("len0_words", 32'(got_q.size()), 32'd0);
        check("len0_done_cnt", 32'(done_cnt), 32'd1);

        // Random backpressure with a 5-cycle hold-off.
        got_q.delete(); done_cnt = 0;
        pulse_start(8'h40, 9'd8);
        for (int c = 0; c < 200 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            if (c >= 4 && c < 9) strm.in_ready = 1'b0;
            else                 strm.in_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1 strm.in_ready = 1'b1;
        check("bp_done", 32'(done_cnt), 32'd1);
        check("bp_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            exp_w = 8'h40 + 8'(i);
            check("bp_word", 32'(got_q[i]), 32'(exp_w));
        end

        // Second start during a burst is ignored.
        got_q.delete(); done_cnt = 0;
        pulse_start(8'h20, 9'd6);
        repeat (2) @(posedge clk);
        pulse_start(8'h90, 9'd3);
        wait_done(40);
        repeat (10) @(negedge clk);
        check("restart_done_cnt", 32'(done_cnt), 32'd1);
        check("restart_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            exp_w = 8'h20 + 8'(i);
            check("restart_word", 32'(got_q[i]), 32'(exp_w));
        end

        // Asynchronous reset after three words, then a fresh burst.
        got_q.delete(); done_cnt = 0;
        pulse_start(8'h30, 9'd8);
        for (int n = 0; n < 40 && got_q.size() < 3; n++) @(negedge clk);
        check("abort_seen3", 32'(got_q.size()), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(strm.out_valid), 32'd0);
        check("abort_data", 32'(strm.out_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_addr", 32'(rom_addr), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        got_q.delete(); done_cnt = 0;
        pulse_start(8'h00, 9'd2);
        wait_done(40);
        repeat (5) @(negedge clk);
        check("post_rst_done_cnt", 32'(done_cnt), 32'd1);
        check("post_rst_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("post_rst_w0", 32'(got_q[0]), 32'h00);
            check("post_rst_w1", 32'(got_q[1]), 32'h01);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
